reset_seq: RTL and testbench
============================

RESET_SEQ -- requirements
Module: reset_seq

Interface
REQ-001 SHALL have parameter NUM_OUT, default 2: number of reset outputs released in sequence; legal range 1..8.
REQ-002 SHALL have parameter STRETCH, default 8: hold cycles after the synchronised external release; legal range 1..65535.
REQ-003 SHALL have parameter STAGGER, default 4: cycles between successive channel releases; 0 releases all channels together.
REQ-004 SHALL have parameter WDT_CYCLES, default 1048576: watchdog timeout in cycles; used only when RESET_SEQ_WDT_EN is defined.
REQ-005 SHALL have port clk  input  1  sole clock.
REQ-006 SHALL have port reset_async  input  1  asynchronous, active-high reset; may be driven by an unsynchronised button or POR.
REQ-007 SHALL have port sw_reset_req  input  1  single-cycle software reset request, clk domain.
REQ-008 SHALL have port wdt_kick  input  1  watchdog restart pulse, clk domain.
REQ-009 SHALL have port resetn  output  NUM_OUT  active-low per-domain resets; channel 0 releases first.
REQ-010 SHALL have port rst_busy  output  1  high while any resetn bit is low.
REQ-011 SHALL have port rst_cause  output  2  cause of the last sequence: 0 external, 1 software, 2 watchdog, 3 reserved.

Function
REQ-012 SHALL implement FSM states HOLD, STRETCH, RELEASE, RUN with a 16-bit down-counter and a channel index.
REQ-013 SHALL pass reset_async through a 2-flop synchroniser; release is seen on the second clk edge after deassertion.
REQ-014 HOLD: all resetn low; exit to STRETCH, counter=STRETCH-1, on the first edge where the synchronised release is seen (edge E).
REQ-015 STRETCH: decrement each edge; at counter 0, raise resetn[0] and enter RELEASE (NUM_OUT>1) or RUN (NUM_OUT=1).
REQ-016 Resulting timing: resetn[i] rises on edge E+STRETCH+i*STAGGER, measured relative to edge E.
REQ-017 RELEASE: raise one further channel every STAGGER cycles; with STAGGER=0, all channels rise on the same edge as channel 0.
REQ-018 Enter RUN on the edge the last channel rises; rst_busy falls on that same edge.
REQ-019 sw_reset_req high in RUN: on the next edge drive all resetn low, set rst_cause=1, load counter=STRETCH-1, enter STRETCH.
REQ-020 sw_reset_req and wdt_kick SHALL be ignored outside RUN.
REQ-021 A released resetn bit SHALL stay high until the next reset sequence; no glitches.
REQ-022 All outputs SHALL be registered.

Reset
REQ-023 reset_async high SHALL immediately, without clk, drive resetn to all zeros and rst_busy to 1, set state HOLD and rst_cause to 0, and clear the synchroniser, counters and watchdog.
REQ-024 reset_async asserted mid-sequence or in RUN SHALL abort; the sequence restarts from HOLD on release.
REQ-025 A reset_async pulse shorter than one clk period SHALL still produce a full sequence.

Configuration
REQ-026 Macro RESET_SEQ_WDT_EN defined: a watchdog counter counts in RUN only and restarts on wdt_kick; on reaching WDT_CYCLES-1 it takes the REQ-019 path with rst_cause=2.
REQ-027 If sw_reset_req and watchdog expiry occur on the same edge, software SHALL win and set rst_cause=1.
REQ-028 Macro RESET_SEQ_WDT_EN undefined: no watchdog logic; wdt_kick is unused; rst_cause is never 2.

Verification
REQ-029 NUM_OUT=3, STRETCH=8, STAGGER=4; deassert reset_async -> resetn[0] rises at E+8, resetn[1] at E+12, resetn[2] at E+16; rst_busy falls at E+16; rst_cause=0.
REQ-030 STAGGER=0 -> all three resetn bits rise on the same edge E+8.
REQ-031 In RUN, one-cycle sw_reset_req -> resetn=000 on the next edge, then the REQ-029 staggered release; rst_cause=1.
REQ-032 Assert reset_async between clk edges during RELEASE -> resetn=000 before the next edge; full sequence restarts; rst_cause=0.
REQ-033 RESET_SEQ_WDT_EN, WDT_CYCLES=100, no kicks -> sequence starts 100 cycles after RUN with rst_cause=2; a kick every 50 cycles -> no reset over 1000 cycles.
REQ-034 RESET_SEQ_WDT_EN: sw_reset_req on the watchdog expiry edge -> single sequence with rst_cause=1.

Source files
------------

// File: rtl/reset_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | reset_seq                                                                  |
// | Staggered multi-domain reset sequencer. Optional watchdog: RESET_SEQ_WDT_EN.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

module reset_seq #(
  parameter int NUM_OUT    = 2,
  parameter int STRETCH    = 8,
  parameter int STAGGER    = 4,
  parameter int WDT_CYCLES = 1048576
) (
  input  logic               clk,
  input  logic               reset_async,
  input  logic               sw_reset_req,
  input  logic               wdt_kick,
  output logic [NUM_OUT-1:0] resetn,
  output logic               rst_busy,
  output logic [1:0]         rst_cause
);

  localparam logic [1:0] S_HOLD    = 2'd0;
  localparam logic [1:0] S_STRETCH = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;
  localparam logic [1:0] S_RUN     = 2'd3;

  localparam logic [1:0] CAUSE_EXT = 2'd0;
  localparam logic [1:0] CAUSE_SW  = 2'd1;
  localparam logic [1:0] CAUSE_WDT = 2'd2;

  localparam logic [15:0] STRETCH_M1 = 16'(STRETCH - 1);
  localparam logic [15:0] STRETCH_M2 = 16'(STRETCH - 2);
  localparam logic [15:0] STAGGER_M1 = 16'(STAGGER - 1);
  localparam logic [2:0]  LAST_IDX   = 3'(NUM_OUT - 1);

  logic [1:0]         sync_q;
  logic [1:0]         state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [2:0]         idx_q, idx_d;
  logic [NUM_OUT-1:0] resetn_q, resetn_d;
  logic               busy_q, busy_d;
  logic [1:0]         cause_q, cause_d;
  logic               first_rel;
  logic               wdt_expire;

`ifdef RESET_SEQ_WDT_EN
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

  logic [WDT_W-1:0] wdt_q, wdt_d;

  always_comb begin
    wdt_d      = '0;
    wdt_expire = 1'b0;
    if (state_q == S_RUN) begin
      if (wdt_kick) begin
        wdt_d = '0;
      end else if (wdt_q == WDT_LAST) begin
        wdt_expire = 1'b1;
      end else begin
        wdt_d = wdt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset_async) begin
    if (reset_async) begin
      wdt_q <= '0;
    end else begin
      wdt_q <= wdt_d;
    end
  end
`else
  logic unused_wdt;

  assign wdt_expire = 1'b0;
  assign unused_wdt = wdt_kick ^ (WDT_CYCLES == 0);
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    resetn_d  = resetn_q;
    busy_d    = busy_q;
    cause_d   = cause_q;
    first_rel = 1'b0;

    case (state_q)
      S_HOLD: begin
        resetn_d = '0;
        busy_d   = 1'b1;
        // The FSM sees the release one edge after the synchroniser does, so
        // the stretch count is preloaded one lower to keep E as the reference.
        if (sync_q[1]) begin
          if (STRETCH == 1) begin
            first_rel = 1'b1;
          end else begin
            cnt_d   = STRETCH_M2;
            state_d = S_STRETCH;
          end
        end
      end

      S_STRETCH: begin
        if (cnt_q == 16'd0) begin
          first_rel = 1'b1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end

      S_RELEASE: begin
        if (cnt_q == 16'd0) begin
          resetn_d = resetn_q | NUM_OUT'(1 << idx_q);
          if (idx_q == LAST_IDX) begin
            busy_d  = 1'b0;
            state_d = S_RUN;
          end else begin
            idx_d = idx_q + 3'd1;
            cnt_d = STAGGER_M1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end

      S_RUN: begin
        // Software request outranks a simultaneous watchdog expiry.
        if (sw_reset_req || wdt_expire) begin
          resetn_d = '0;
          busy_d   = 1'b1;
          cause_d  = sw_reset_req ? CAUSE_SW : CAUSE_WDT;
          cnt_d    = STRETCH_M1;
          idx_d    = 3'd0;
          state_d  = S_STRETCH;
        end
      end

      default: begin
        state_d = S_HOLD;
      end
    endcase

    if (first_rel) begin
      if (STAGGER == 0 || NUM_OUT == 1) begin
        resetn_d = '1;
        busy_d   = 1'b0;
        state_d  = S_RUN;
      end else begin
        resetn_d = NUM_OUT'(1);
        cnt_d    = STAGGER_M1;
        idx_d    = 3'd1;
        state_d  = S_RELEASE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset_async) begin
    if (reset_async) begin
      sync_q   <= 2'b00;
      state_q  <= S_HOLD;
      cnt_q    <= 16'd0;
      idx_q    <= 3'd0;
      resetn_q <= '0;
      busy_q   <= 1'b1;
      cause_q  <= CAUSE_EXT;
    end else begin
      sync_q   <= {sync_q[0], 1'b1};
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      resetn_q <= resetn_d;
      busy_q   <= busy_d;
      cause_q  <= cause_d;
    end
  end

  assign resetn    = resetn_q;
  assign rst_busy  = busy_q;
  assign rst_cause = cause_q;

endmodule

`default_nettype wire

// File: tb/tb_reset_seq.sv
`default_nettype none
// Bench for reset_seq: three configurations driven in parallel and checked
// against an edge-count timing model of the release schedule.

module tb_reset_seq;

  localparam int ND  = 3;
  localparam int BIG = 1 << 28;
  localparam int WDT = 100;

  localparam int CFG_N [ND] = '{3, 3, 1};
  localparam int CFG_S [ND] = '{8, 8, 1};
  localparam int CFG_G [ND] = '{4, 0, 4};

  logic clk = 1'b0;
  logic reset_async;
  logic sw_reset_req;
  logic wdt_kick;

  logic [2:0] rn_a, rn_b;
  logic [0:0] rn_c;
  logic       busy_a, busy_b, busy_c;
  logic [1:0] cause_a, cause_b, cause_c;

  int n;
  int n_checks;
  int n_fail;
  int seq_e [ND];
  int exp_cause [ND];
  int wref [ND];

  always #5 clk = ~clk;

  reset_seq #(.NUM_OUT(3), .STRETCH(8), .STAGGER(4), .WDT_CYCLES(WDT)) u_a (
    .clk(clk), .reset_async(reset_async), .sw_reset_req(sw_reset_req),
    .wdt_kick(wdt_kick), .resetn(rn_a), .rst_busy(busy_a), .rst_cause(cause_a)
  );

  reset_seq #(.NUM_OUT(3), .STRETCH(8), .STAGGER(0), .WDT_CYCLES(WDT)) u_b (
    .clk(clk), .reset_async(reset_async), .sw_reset_req(sw_reset_req),
    .wdt_kick(wdt_kick), .resetn(rn_b), .rst_busy(busy_b), .rst_cause(cause_b)
  );

  reset_seq #(.NUM_OUT(1), .STRETCH(1), .STAGGER(4), .WDT_CYCLES(WDT)) u_c (
    .clk(clk), .reset_async(reset_async), .sw_reset_req(sw_reset_req),
    .wdt_kick(wdt_kick), .resetn(rn_c), .rst_busy(busy_c), .rst_cause(cause_c)
  );

  // Edge on which the last channel of configuration d is released.
  function automatic int last_edge(int d);
    return seq_e[d] + CFG_S[d] + (CFG_N[d] - 1) * CFG_G[d];
  endfunction

  function automatic logic [7:0] exp_rn(int d);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < CFG_N[d]; i++) begin
      r[i] = (n >= seq_e[d] + CFG_S[d] + i * CFG_G[d]);
    end
    return r;
  endfunction

  task automatic check_all(input string tag);
    logic [7:0] o_rn [ND];
    logic       o_busy [ND];
    logic [1:0] o_cause [ND];
    logic       e_busy;
    o_rn[0] = {5'b0, rn_a};  o_busy[0] = busy_a;  o_cause[0] = cause_a;
    o_rn[1] = {5'b0, rn_b};  o_busy[1] = busy_b;  o_cause[1] = cause_b;
    o_rn[2] = {7'b0, rn_c};  o_busy[2] = busy_c;  o_cause[2] = cause_c;
    for (int d = 0; d < ND; d++) begin
      n_checks++;
      assert (o_rn[d] === exp_rn(d)) else begin
        n_fail++;
        $error("FAIL %s resetn dut%0d edge%0d: got %b want %b", tag, d, n, o_rn[d], exp_rn(d));
      end
      e_busy = (n < last_edge(d));
      n_checks++;
      assert (o_busy[d] === e_busy) else begin
        n_fail++;
        $error("FAIL %s rst_busy dut%0d edge%0d: got %b want %b", tag, d, n, o_busy[d], e_busy);
      end
      n_checks++;
      assert (o_cause[d] === 2'(exp_cause[d])) else begin
        n_fail++;
        $error("FAIL %s rst_cause dut%0d edge%0d: got %0d want %0d", tag, d, n, o_cause[d], exp_cause[d]);
      end
    end
  endtask

  // One clock edge: advance the model with the inputs sampled on it, then check.
  task automatic tick();
    int l;
    @(posedge clk);
    n++;
    for (int d = 0; d < ND; d++) begin
      l = last_edge(d);
      if (!reset_async && n > l) begin
        if (sw_reset_req) begin
          seq_e[d]     = n;
          exp_cause[d] = 1;
        end
`ifdef RESET_SEQ_WDT_EN
        else if (wdt_kick) begin
          wref[d] = n;
        end else if (n == ((wref[d] > l) ? wref[d] : l) + WDT) begin
          seq_e[d]     = n;
          exp_cause[d] = 2;
        end
`endif
      end
    end
    #1;
    check_all("tick");
  endtask

  // Called 1 time unit after an edge; deasserts before the next edge.
  task automatic release_ext();
    #3 reset_async = 1'b0;
    for (int d = 0; d < ND; d++) seq_e[d] = n + 2;
  endtask

  task automatic async_pulse(input int hold);
    #2 reset_async = 1'b1;
    for (int d = 0; d < ND; d++) begin
      seq_e[d]     = BIG;
      exp_cause[d] = 0;
    end
    #1 check_all("async_assert");
    if (hold == 0) begin
      #1 reset_async = 1'b0;
      for (int d = 0; d < ND; d++) seq_e[d] = n + 2;
    end else begin
      repeat (hold) tick();
      release_ext();
    end
  endtask

  initial begin
    n = 0;
    n_checks = 0;
    n_fail = 0;
    for (int d = 0; d < ND; d++) begin
      seq_e[d]     = BIG;
      exp_cause[d] = 0;
      wref[d]      = 0;
    end
    sw_reset_req = 1'b0;
    wdt_kick     = 1'b0;
    reset_async  = 1'b0;
    #1 reset_async = 1'b1;
    #1 check_all("por");

    repeat (3) tick();
    release_ext();
    repeat (30) tick();

    sw_reset_req = 1'b1;
    tick();
    sw_reset_req = 1'b0;
    repeat (25) tick();

    // Abort while configuration 0 is between its second and third release.
    async_pulse(0);
    while (n < seq_e[0] + 13) tick();
    async_pulse(2);
    repeat (30) tick();

    async_pulse(0);
    repeat (30) tick();

    for (int k = 0; k < 400; k++) begin
      sw_reset_req = ($urandom_range(0, 9) == 0);
      wdt_kick     = 1'($urandom_range(0, 1));
      tick();
      if ($urandom_range(0, 79) == 0) async_pulse($urandom_range(0, 2));
    end
    sw_reset_req = 1'b0;
    wdt_kick     = 1'b0;

`ifdef RESET_SEQ_WDT_EN
    async_pulse(0);
    repeat (150) tick();
    repeat (30) tick();
    for (int k = 0; k < 1000; k++) begin
      wdt_kick = (k % 50 == 0);
      tick();
    end
    wdt_kick = 1'b0;

    async_pulse(0);
    repeat (20) tick();
    while (n < last_edge(0) + 99) tick();
    sw_reset_req = 1'b1;
    tick();
    sw_reset_req = 1'b0;
    repeat (30) tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
